sa_wb_data_cache: RTL

//  Parametrised N-way set-associative, write-back, write-allocate L1 data cache.

---
 rtl/sa_wb_data_cache.sv | 330 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/sa_wb_data_cache.sv
// N-way set-associative, write-back, write-allocate L1 data cache.
// Sits between the core data port and the memory arbiter. Dirty lines go to
// memory only when they are evicted. Each set has its own round-robin victim
// pointer, and hits finish without any memory traffic.
module sa_wb_data_cache #(
    parameter int WORDSIZE      = 64,
    parameter int LOGSETS       = 6,
    parameter int LOGLINEOFFSET = 3,
    parameter int WAYS          = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                reqcyc,
    output logic                reqack,
    input  logic [WORDSIZE-1:0] req,
    input  logic                reqwrite,
    input  logic [WORDSIZE-1:0] reqdata,
    output logic                respcyc,
    input  logic                respack,
    output logic [WORDSIZE-1:0] resp,
    output logic                mem_reqcyc,
    input  logic                mem_reqack,
    output logic [WORDSIZE-1:0] mem_req,
    output logic                mem_write,
    input  logic                mem_respcyc,
    output logic                mem_respack,
    input  logic [WORDSIZE-1:0] mem_resp
);
    localparam int TAGW      = WORDSIZE - LOGSETS - LOGLINEOFFSET - 3;
    localparam int SETS      = 1 << LOGSETS;
    localparam int LINEWORDS = 1 << LOGLINEOFFSET;
    localparam int WAYW      = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int OFFW      = LOGLINEOFFSET + 3;
    localparam int BCW       = LOGLINEOFFSET + 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOOKUP   = 3'd1,
        WB_ADDR  = 3'd2,
        WB_DATA  = 3'd3,
        FILL_REQ = 3'd4,
        FILL     = 3'd5,
        RESPOND  = 3'd6
    } state_t;

    // Line storage and per-set bookkeeping
    logic [WORDSIZE-1:0] data_q  [WAYS][SETS][LINEWORDS];
    logic [TAGW-1:0]     tag_q   [WAYS][SETS];
    logic [WAYS-1:0]     valid_q [SETS];
    logic [WAYS-1:0]     dirty_q [SETS];
    logic [WAYW-1:0]     rr_q    [SETS];

    // Controller registers
    state_t               state_q, state_d;
    logic [WORDSIZE-1:3]  req_line_q, req_line_d;
    logic                 req_write_q, req_write_d;
    logic [WORDSIZE-1:0]  req_data_q, req_data_d;
    logic [WAYW-1:0]      way_q, way_d;
    logic [BCW-1:0]       beat_cnt_q, beat_cnt_d;
    logic                 reqack_q, reqack_d;
    logic                 respcyc_q, respcyc_d;
    logic [WORDSIZE-1:0]  resp_q, resp_d;
    logic                 mem_reqcyc_q, mem_reqcyc_d;
    logic [WORDSIZE-1:0]  mem_req_q, mem_req_d;
    logic                 mem_write_q, mem_write_d;

    // Address fields of the captured request
    logic [TAGW-1:0]          tag_s;
    logic [LOGSETS-1:0]       set_s;
    logic [LOGLINEOFFSET-1:0] word_s;
    logic [WORDSIZE-1:0]      line_addr_s;
    logic [BCW-1:0]           beat_nxt_s;

    // Lookup results
    logic            hit_s;
    logic [WAYW-1:0] hit_way_s;
    logic            inv_found_s;
    logic [WAYW-1:0] inv_way_s;
    logic [WAYW-1:0] victim_s;
    logic [WAYW-1:0] rr_nxt_s;

    // Storage update strobes
    logic            fill_we_s;
    logic            st_we_s;
    logic [WAYW-1:0] st_way_s;
    logic            install_s;
    logic            dirty_clr_s;
    logic            rr_inc_s;

    // The cache works on whole words, so the byte offset has no effect
    logic unused_ok_s;
    assign unused_ok_s = ^req[2:0];

    assign tag_s       = req_line_q[WORDSIZE-1 -: TAGW];
    assign set_s       = req_line_q[OFFW +: LOGSETS];
    assign word_s      = req_line_q[3 +: LOGLINEOFFSET];
    assign line_addr_s = {req_line_q[WORDSIZE-1:OFFW], {OFFW{1'b0}}};
    assign beat_nxt_s  = beat_cnt_q + BCW'(1);
    assign victim_s    = inv_found_s ? inv_way_s : rr_q[set_s];
    assign rr_nxt_s    = (rr_q[set_s] == WAYW'(WAYS - 1)) ? {WAYW{1'b0}} : rr_q[set_s] + WAYW'(1);

    assign reqack      = reqack_q;
    assign respcyc     = respcyc_q;
    assign resp        = resp_q;
    assign mem_reqcyc  = mem_reqcyc_q;
    assign mem_req     = mem_req_q;
    assign mem_write   = mem_write_q;
    assign mem_respack = (state_q == FILL);

    // Tag match and first-invalid-way search across all ways of the set
    always_comb begin
        hit_s       = 1'b0;
        hit_way_s   = {WAYW{1'b0}};
        inv_found_s = 1'b0;
        inv_way_s   = {WAYW{1'b0}};
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[set_s][w] && (tag_q[w][set_s] == tag_s) && !hit_s) begin
                hit_s     = 1'b1;
                hit_way_s = WAYW'(w);
            end else begin
                hit_s     = hit_s;
            end
            if (!valid_q[set_s][w] && !inv_found_s) begin
                inv_found_s = 1'b1;
                inv_way_s   = WAYW'(w);
            end else begin
                inv_found_s = inv_found_s;
            end
        end
    end

    // Controller next-state, next-output and storage strobe logic
    always_comb begin
        state_d      = state_q;
        req_line_d   = req_line_q;
        req_write_d  = req_write_q;
        req_data_d   = req_data_q;
        way_d        = way_q;
        beat_cnt_d   = beat_cnt_q;
        reqack_d     = 1'b0;
        respcyc_d    = respcyc_q;
        resp_d       = resp_q;
        mem_reqcyc_d = mem_reqcyc_q;
        mem_req_d    = mem_req_q;
        mem_write_d  = mem_write_q;
        fill_we_s    = 1'b0;
        st_we_s      = 1'b0;
        st_way_s     = way_q;
        install_s    = 1'b0;
        dirty_clr_s  = 1'b0;
        rr_inc_s     = 1'b0;
        case (state_q)
            IDLE: begin
                if (reqcyc) begin
                    req_line_d  = req[WORDSIZE-1:3];
                    req_write_d = reqwrite;
                    req_data_d  = reqdata;
                    reqack_d    = 1'b1;
                    state_d     = LOOKUP;
                end else begin
                    state_d     = IDLE;
                end
            end
            LOOKUP: begin
                if (hit_s) begin
                    way_d    = hit_way_s;
                    st_we_s  = req_write_q;
                    st_way_s = hit_way_s;
                    state_d  = RESPOND;
                end else begin
                    way_d        = victim_s;
                    rr_inc_s     = !inv_found_s && (WAYS > 1);
                    mem_reqcyc_d = 1'b1;
                    if (valid_q[set_s][victim_s] && dirty_q[set_s][victim_s]) begin
                        mem_write_d = 1'b1;
                        mem_req_d   = {tag_q[victim_s][set_s], set_s, {OFFW{1'b0}}};
                        state_d     = WB_ADDR;
                    end else begin
                        mem_write_d = 1'b0;
                        mem_req_d   = line_addr_s;
                        state_d     = FILL_REQ;
                    end
                end
            end
            WB_ADDR: begin
                if (mem_reqack) begin
                    mem_req_d  = data_q[way_q][set_s][0];
                    beat_cnt_d = {BCW{1'b0}};
                    state_d    = WB_DATA;
                end else begin
                    state_d    = WB_ADDR;
                end
            end
            WB_DATA: begin
                if (mem_reqack) begin
                    if (beat_nxt_s == BCW'(LINEWORDS)) begin
                        dirty_clr_s = 1'b1;
                        mem_write_d = 1'b0;
                        mem_req_d   = line_addr_s;
                        beat_cnt_d  = {BCW{1'b0}};
                        state_d     = FILL_REQ;
                    end else begin
                        beat_cnt_d  = beat_nxt_s;
                        mem_req_d   = data_q[way_q][set_s][beat_nxt_s[LOGLINEOFFSET-1:0]];
                    end
                end else begin
                    state_d = WB_DATA;
                end
            end
            FILL_REQ: begin
                if (mem_reqack) begin
                    mem_reqcyc_d = 1'b0;
                    mem_write_d  = 1'b0;
                    mem_req_d    = {WORDSIZE{1'b0}};
                    beat_cnt_d   = {BCW{1'b0}};
                    state_d      = FILL;
                end else begin
                    state_d      = FILL_REQ;
                end
            end
            FILL: begin
                if (mem_respcyc) begin
                    fill_we_s  = 1'b1;
                    beat_cnt_d = beat_nxt_s;
                    if (beat_nxt_s == BCW'(LINEWORDS)) begin
                        install_s  = 1'b1;
                        st_we_s    = req_write_q;
                        st_way_s   = way_q;
                        beat_cnt_d = {BCW{1'b0}};
                        state_d    = RESPOND;
                    end else begin
                        state_d    = FILL;
                    end
                end else begin
                    state_d = FILL;
                end
            end
            RESPOND: begin
                if (!respcyc_q) begin
                    respcyc_d = 1'b1;
                    resp_d    = req_write_q ? {WORDSIZE{1'b0}} : data_q[way_q][set_s][word_s];
                end else if (respack) begin
                    respcyc_d = 1'b0;
                    resp_d    = {WORDSIZE{1'b0}};
                    state_d   = IDLE;
                end else begin
                    state_d   = RESPOND;
                end
            end
            default: begin
                state_d      = IDLE;
                respcyc_d    = 1'b0;
                resp_d       = {WORDSIZE{1'b0}};
                mem_reqcyc_d = 1'b0;
                mem_req_d    = {WORDSIZE{1'b0}};
                mem_write_d  = 1'b0;
            end
        endcase
    end

    // Controller state and registered outputs; reset abandons any burst
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            req_line_q   <= {(WORDSIZE-3){1'b0}};
            req_write_q  <= 1'b0;
            req_data_q   <= {WORDSIZE{1'b0}};
            way_q        <= {WAYW{1'b0}};
            beat_cnt_q   <= {BCW{1'b0}};
            reqack_q     <= 1'b0;
            respcyc_q    <= 1'b0;
            resp_q       <= {WORDSIZE{1'b0}};
            mem_reqcyc_q <= 1'b0;
            mem_req_q    <= {WORDSIZE{1'b0}};
            mem_write_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_line_q   <= req_line_d;
            req_write_q  <= req_write_d;
            req_data_q   <= req_data_d;
            way_q        <= way_d;
            beat_cnt_q   <= beat_cnt_d;
            reqack_q     <= reqack_d;
            respcyc_q    <= respcyc_d;
            resp_q       <= resp_d;
            mem_reqcyc_q <= mem_reqcyc_d;
            mem_req_q    <= mem_req_d;
            mem_write_q  <= mem_write_d;
        end
    end

    // Data and tag arrays; a store merge overrides the fill beat of the same word
    always_ff @(posedge clk) begin
        if (fill_we_s) begin
            data_q[way_q][set_s][beat_cnt_q[LOGLINEOFFSET-1:0]] <= mem_resp;
        end
        if (st_we_s) begin
            data_q[st_way_s][set_s][word_s] <= req_data_q;
        end
        if (install_s) begin
            tag_q[way_q][set_s] <= tag_s;
        end
    end

    // Valid, dirty and round-robin state; cleared by reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= {WAYS{1'b0}};
                dirty_q[s] <= {WAYS{1'b0}};
                rr_q[s]    <= {WAYW{1'b0}};
            end
        end else begin
            if (install_s) begin
                valid_q[set_s][way_q] <= 1'b1;
                dirty_q[set_s][way_q] <= 1'b0;
            end
            if (st_we_s) begin
                dirty_q[set_s][st_way_s] <= 1'b1;
            end
            if (dirty_clr_s) begin
                dirty_q[set_s][way_q] <= 1'b0;
            end
            if (rr_inc_s) begin
                rr_q[set_s] <= rr_nxt_s;
            end
        end
    end

endmodule
